// File: rtl/inv_rho_rotate_if.sv
// rtl/inv_rho_rotate_if.sv - start/done handshake and state-memory port bundle for inv_rho_rotate
interface inv_rho_rotate_if #(
    parameter int W  = 64,
    parameter int AW = 5
);
    logic          start;
    logic          busy;
    logic          done;
    logic          mem_rd_en;
    logic [AW-1:0] mem_rd_addr;
    logic [W-1:0]  mem_rd_data;
    logic          mem_wr_en;
    logic [AW-1:0] mem_wr_addr;
    logic [W-1:0]  mem_wr_data;

    modport master (
        input  start,
        input  mem_rd_data,
        output busy,
        output done,
        output mem_rd_en,
        output mem_rd_addr,
        output mem_wr_en,
        output mem_wr_addr,
        output mem_wr_data
    );

    modport slave (
        output start,
        output mem_rd_data,
        input  busy,
        input  done,
        input  mem_rd_en,
        input  mem_rd_addr,
        input  mem_wr_en,
        input  mem_wr_addr,
        input  mem_wr_data
    );
endinterface

// File: rtl/inv_rho_rotate.sv
// rtl/inv_rho_rotate.sv - inverse rho: rotate each lane right by its offset, in place
// Define INV_RHO_ROTATE_BARREL_EN for a single-cycle barrel rotate instead of the bit-serial shifter.
module inv_rho_rotate #(
    parameter int W  = 64,
    parameter int AW = 5
) (
    input  logic             clk,
    input  logic             rst,
    inv_rho_rotate_if.master bus
);
    localparam int            CW         = (W > 2) ? $clog2(W) : 1;
    localparam logic [AW-1:0] FIRST_LANE = AW'(1);
    localparam logic [AW-1:0] LAST_LANE  = AW'(24);

    typedef enum logic [2:0] {
        IDLE,
        READ,
        LOAD,
        SHIFT,
        WRITE,
        NEXT_LANE,
        DONE
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] lane;
    logic [CW-1:0] cnt;
    logic [CW-1:0] k;
    logic [W-1:0]  sreg;

    function automatic logic [7:0] rho_offset(input logic [AW-1:0] idx);
        case (int'(idx))
            1:       return 8'd1;
            2:       return 8'd62;
            3:       return 8'd28;
            4:       return 8'd27;
            5:       return 8'd36;
            6:       return 8'd44;
            7:       return 8'd6;
            8:       return 8'd55;
            9:       return 8'd20;
            10:      return 8'd3;
            11:      return 8'd10;
            12:      return 8'd43;
            13:      return 8'd25;
            14:      return 8'd39;
            15:      return 8'd41;
            16:      return 8'd45;
            17:      return 8'd15;
            18:      return 8'd21;
            19:      return 8'd8;
            20:      return 8'd18;
            21:      return 8'd2;
            22:      return 8'd61;
            23:      return 8'd56;
            24:      return 8'd14;
            default: return 8'd0;
        endcase
    endfunction

    always_comb begin
        k = CW'(int'(rho_offset(lane)) % W);
    end

`ifdef INV_RHO_ROTATE_BARREL_EN
    // Doubling the word turns a rotate into a plain shift; the low half is the result.
    logic [W-1:0] rot;
    always_comb begin
        rot = W'({sreg, sreg} >> cnt);
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx        = state;
        bus.busy        = (state != IDLE);
        bus.done        = 1'b0;
        bus.mem_rd_en   = 1'b0;
        bus.mem_rd_addr = '0;
        bus.mem_wr_en   = 1'b0;
        bus.mem_wr_addr = '0;
        bus.mem_wr_data = '0;
        case (state)
            IDLE: begin
                if (bus.start) state_nx = READ;
            end
            READ: begin
                bus.mem_rd_en   = 1'b1;
                bus.mem_rd_addr = lane;
                state_nx        = LOAD;
            end
            LOAD: begin
`ifdef INV_RHO_ROTATE_BARREL_EN
                state_nx = SHIFT;
`else
                state_nx = (k != '0) ? SHIFT : WRITE;
`endif
            end
            SHIFT: begin
`ifdef INV_RHO_ROTATE_BARREL_EN
                state_nx = WRITE;
`else
                if (cnt <= CW'(1)) state_nx = WRITE;
`endif
            end
            WRITE: begin
                // Lane advance lives here, so NEXT_LANE never takes a cycle of its own.
                bus.mem_wr_en   = 1'b1;
                bus.mem_wr_addr = lane;
                bus.mem_wr_data = sreg;
                state_nx        = (lane == LAST_LANE) ? DONE : READ;
            end
            NEXT_LANE: begin
                state_nx = READ;
            end
            DONE: begin
                bus.done = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lane <= FIRST_LANE;
            cnt  <= '0;
            sreg <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) lane <= FIRST_LANE;
                end
                LOAD: begin
                    sreg <= bus.mem_rd_data;
                    cnt  <= k;
                end
                SHIFT: begin
`ifdef INV_RHO_ROTATE_BARREL_EN
                    sreg <= rot;
                    cnt  <= '0;
`else
                    sreg <= {sreg[0], sreg[W-1:1]};
                    cnt  <= cnt - 1'b1;
`endif
                end
                WRITE: begin
                    if (lane != LAST_LANE) lane <= lane + 1'b1;
                end
                DONE: begin
                    lane <= FIRST_LANE;
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_inv_rho_rotate.sv
// tb/tb_inv_rho_rotate.sv - scoreboard bench for inv_rho_rotate at W=64 and W=8
module tb_inv_rho_rotate;
`ifdef INV_RHO_ROTATE_BARREL_EN
    localparam int LAT    = 97;
    localparam int MID_AT = 50;
`else
    localparam int LAT    = 753;
    localparam int MID_AT = 100;
`endif
    localparam int RST_AT = 2 * MID_AT;

    typedef struct packed {
        logic [4:0]  addr;
        logic [63:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic load = 1'b0;
    always #5 clk = ~clk;

    inv_rho_rotate_if #(.W(64), .AW(5)) bus ();
    inv_rho_rotate_if #(.W(8),  .AW(5)) bus8 ();

    inv_rho_rotate #(.W(64), .AW(5)) dut  (.clk(clk), .rst(rst), .bus(bus));
    inv_rho_rotate #(.W(8),  .AW(5)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    int unsigned rho [25] = '{0, 1, 62, 28, 27, 36, 44, 6, 55, 20, 3, 10, 43, 25, 39,
                              41, 45, 15, 21, 8, 18, 2, 61, 56, 14};

    logic [63:0] mem   [25];
    logic [63:0] init  [25];
    logic [7:0]  mem8  [25];
    logic [7:0]  init8 [25];

    always @(posedge clk) begin
        if (load) begin
            mem  <= init;
            mem8 <= init8;
        end else begin
            if (bus.mem_wr_en)  mem[bus.mem_wr_addr]   <= bus.mem_wr_data;
            if (bus8.mem_wr_en) mem8[bus8.mem_wr_addr] <= bus8.mem_wr_data;
        end
        bus.mem_rd_data  <= bus.mem_rd_en  ? mem[bus.mem_rd_addr]   : 64'd0;
        bus8.mem_rd_data <= bus8.mem_rd_en ? mem8[bus8.mem_rd_addr] : 8'd0;
    end

    wr_t exp_q[$];
    wr_t got_q[$];
    int  n_chk  = 0;
    int  n_fail = 0;
    int  busy_cyc, done_cyc, done_cnt, wr_cnt, viol, tmo;

    function automatic logic [63:0] rotl(input logic [63:0] v, input int k);
        if (k == 0) return v;
        return (v << k) | (v >> (64 - k));
    endfunction

    task automatic load_state();
        @(negedge clk);
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Drives one start pulse and records what the selected DUT does until it drops busy.
    task automatic run_pass(input bit w8, input int restart_at);
        int c;
        logic b, d, re, we;
        logic [4:0] ra, wa;
        logic [63:0] wd;
        busy_cyc = 0; done_cyc = 0; done_cnt = 0; wr_cnt = 0; viol = 0; tmo = 1;
        got_q.delete();
        @(negedge clk);
        if (w8) bus8.start = 1'b1; else bus.start = 1'b1;
        c = 0;
        while (c < 3000) begin
            @(negedge clk);
            c++;
            if (c == 1 || c == restart_at + 1) begin bus.start = 1'b0; bus8.start = 1'b0; end
            if (c == restart_at) begin
                if (w8) bus8.start = 1'b1; else bus.start = 1'b1;
            end
            b  = w8 ? bus8.busy        : bus.busy;
            d  = w8 ? bus8.done        : bus.done;
            re = w8 ? bus8.mem_rd_en   : bus.mem_rd_en;
            we = w8 ? bus8.mem_wr_en   : bus.mem_wr_en;
            ra = w8 ? bus8.mem_rd_addr : bus.mem_rd_addr;
            wa = w8 ? bus8.mem_wr_addr : bus.mem_wr_addr;
            wd = w8 ? {56'd0, bus8.mem_wr_data} : bus.mem_wr_data;
            if (b) busy_cyc++;
            if (d) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = c;
            end
            if (re && we) viol++;
            if (!re && ra != 5'd0) viol++;
            if (!we && wa != 5'd0) viol++;
            if (we) begin
                wr_cnt++;
                if (wa == 5'd0) viol++;
                got_q.push_back('{addr: wa, data: wd});
            end
            if (!b) begin
                tmo = 0;
                break;
            end
        end
        bus.start = 1'b0;
        bus8.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0;
        bus8.start = 1'b0;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_rd_addr, bus.mem_wr_addr} !== 14'd0
            || bus.mem_wr_data !== 64'd0) begin
            n_fail++;
            $display("FAIL reset_during: outputs busy=%b done=%b rd=%b wr=%b, required all 0",
                     bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus8.busy, bus8.mem_rd_en} !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_after: outputs busy=%b done=%b rd=%b wr=%b, required all 0",
                     bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en);
        end
    endtask

    task automatic test_basic();
        wr_t e, g;
        for (int l = 0; l < 25; l++) begin init[l] = 64'd0; init8[l] = 8'd0; end
        init[0] = 64'hDEADBEEFDEADBEEF;
        init[1] = 64'd1;
        init[2] = 64'd1;
        load_state();
        for (int l = 1; l < 25; l++)
            exp_q.push_back('{addr: 5'(l),
                              data: (l == 1) ? 64'h8000000000000000 : (l == 2) ? 64'h4 : 64'h0});
        run_pass(1'b0, -10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL basic_write: no write, required addr %0d data %h", e.addr, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL basic_write: got addr %0d data %h, required addr %0d data %h",
                             g.addr, g.data, e.addr, e.data);
                end
            end
        end
        n_chk++;
        if (mem[1] !== 64'h8000000000000000 || mem[2] !== 64'h4) begin
            n_fail++;
            $display("FAIL basic_mem: lane1=%h lane2=%h, required 8000000000000000 and 4", mem[1], mem[2]);
        end
        n_chk++;
        if (mem[0] !== 64'hDEADBEEFDEADBEEF) begin
            n_fail++;
            $display("FAIL basic_lane0: got %h, required deadbeefdeadbeef", mem[0]);
        end
        n_chk++;
        if (viol !== 0) begin
            n_fail++;
            $display("FAIL basic_bus_rules: %0d violations, required 0", viol);
        end
    endtask

    task automatic test_random();
        logic [63:0] orig [25];
        wr_t e, g;
        int bad;
        for (int s = 0; s < 20; s++) begin
            for (int l = 0; l < 25; l++) begin
                orig[l] = {$urandom, $urandom};
                init[l] = rotl(orig[l], int'(rho[l] % 64));
                if (l > 0) exp_q.push_back('{addr: 5'(l), data: orig[l]});
            end
            load_state();
            run_pass(1'b0, -10);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                n_chk++;
                if (got_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL random_write: pass %0d no write, required addr %0d", s, e.addr);
                end else begin
                    g = got_q.pop_front();
                    if (g !== e) begin
                        n_fail++;
                        $display("FAIL random_write: pass %0d got addr %0d data %h, required addr %0d data %h",
                                 s, g.addr, g.data, e.addr, e.data);
                    end
                end
            end
            bad = 0;
            for (int l = 0; l < 25; l++) if (mem[l] !== orig[l]) bad++;
            n_chk++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL random_mem: pass %0d has %0d differing lanes, required 0", s, bad);
            end
        end
    endtask

    task automatic test_latency(input string name, input int restart_at);
        for (int l = 0; l < 25; l++) init[l] = {$urandom, $urandom};
        load_state();
        run_pass(1'b0, restart_at);
        n_chk++;
        if (tmo != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: busy never dropped within 3000 cycles", name);
        end
        n_chk++;
        if (busy_cyc != LAT) begin
            n_fail++;
            $display("FAIL %s_busy: busy high %0d cycles, required %0d", name, busy_cyc, LAT);
        end
        n_chk++;
        if (done_cyc != LAT || done_cnt != 1) begin
            n_fail++;
            $display("FAIL %s_done: done at cycle %0d (%0d pulses), required cycle %0d (1 pulse)",
                     name, done_cyc, done_cnt, LAT);
        end
        n_chk++;
        if (wr_cnt != 24 || viol != 0) begin
            n_fail++;
            $display("FAIL %s_writes: %0d writes %0d violations, required 24 and 0", name, wr_cnt, viol);
        end
    endtask

    task automatic test_abort();
        logic [63:0] orig [25];
        int bad, act;
        for (int l = 0; l < 25; l++) init[l] = {$urandom, $urandom};
        load_state();
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (RST_AT - 1) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.mem_rd_en, bus.mem_wr_en, bus.mem_rd_addr, bus.mem_wr_addr} !== 14'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: busy=%b rd=%b wr=%b, required all 0",
                     bus.busy, bus.mem_rd_en, bus.mem_wr_en);
        end
        rst = 1'b0;
        act = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.busy || bus.mem_rd_en || bus.mem_wr_en) act++;
        end
        n_chk++;
        if (act != 0) begin
            n_fail++;
            $display("FAIL abort_idle: %0d active cycles after reset, required 0", act);
        end
        for (int l = 0; l < 25; l++) begin
            orig[l] = {$urandom, $urandom};
            init[l] = rotl(orig[l], int'(rho[l] % 64));
        end
        load_state();
        run_pass(1'b0, -10);
        bad = 0;
        for (int l = 0; l < 25; l++) if (mem[l] !== orig[l]) bad++;
        n_chk++;
        if (bad != 0 || busy_cyc != LAT || wr_cnt != 24) begin
            n_fail++;
            $display("FAIL abort_rerun: %0d bad lanes, busy %0d, writes %0d, required 0, %0d, 24",
                     bad, busy_cyc, wr_cnt, LAT);
        end
    endtask

    task automatic test_hold();
        int seen_done;
        seen_done = 0;
        @(negedge clk);
        bus.start = 1'b1;
        for (int c = 1; c <= LAT + 2; c++) begin
            @(negedge clk);
            if (bus.done) seen_done = c;
            if (c == LAT + 1) begin
                n_chk++;
                if (bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL hold_idle: busy=%b one cycle after done, required 0", bus.busy);
                end
            end
            if (c == LAT + 2) begin
                n_chk++;
                if (bus.busy !== 1'b1 || bus.mem_rd_en !== 1'b1 || bus.mem_rd_addr !== 5'd1
                    || seen_done != LAT) begin
                    n_fail++;
                    $display("FAIL hold_restart: busy=%b rd=%b addr=%0d done_at=%0d, required 1 1 1 %0d",
                             bus.busy, bus.mem_rd_en, bus.mem_rd_addr, seen_done, LAT);
                end
            end
        end
        bus.start = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_w8();
        wr_t e, g;
        for (int l = 0; l < 25; l++) init8[l] = 8'd0;
        init8[0] = 8'hA5;
        init8[1] = 8'h01;
        init8[2] = 8'h01;
        init8[7] = 8'h01;
        load_state();
        for (int l = 1; l < 25; l++)
            exp_q.push_back('{addr: 5'(l),
                              data: (l == 1) ? 64'h80 : (l == 2 || l == 7) ? 64'h04 : 64'h0});
        run_pass(1'b1, -10);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (got_q.size() == 0) begin
                n_fail++;
                $display("FAIL w8_write: no write, required addr %0d data %h", e.addr, e.data);
            end else begin
                g = got_q.pop_front();
                if (g !== e) begin
                    n_fail++;
                    $display("FAIL w8_write: got addr %0d data %h, required addr %0d data %h",
                             g.addr, g.data, e.addr, e.data);
                end
            end
        end
        n_chk++;
        if (mem8[2] !== 8'h04 || mem8[7] !== 8'h04 || mem8[0] !== 8'hA5) begin
            n_fail++;
            $display("FAIL w8_mem: lane2=%h lane7=%h lane0=%h, required 04 04 a5", mem8[2], mem8[7], mem8[0]);
        end
        n_chk++;
        if (wr_cnt != 24 || viol != 0) begin
            n_fail++;
            $display("FAIL w8_writes: %0d writes %0d violations, required 24 and 0", wr_cnt, viol);
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus8.start = 1'b0;
        test_reset();
        test_basic();
        test_random();
        test_latency("latency", -10);
        test_latency("restart_ignored", MID_AT);
        test_abort();
        test_hold();
        test_w8();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/inv_rho_rotate.md
Name: inv_rho_rotate

Overview:
Inverse of the lane-rotate (rho) step of the 5x5xW state encoder. It undoes the forward rotation: each lane is read from the state memory, rotated RIGHT by its rho offset, and written back in place. It sits on the decode path after the inverse-pi stage and shares the single-port-per-direction state memory interface. Start/done handshake to the top-level sequencer.

Parameters:
W, 64, lane width in bits; the effective shift for every lane is (rho offset mod W)
AW, 5, lane address width (25 lanes, addresses 0..24, address = x + 5*y)

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  begin one inverse-rotate pass; sampled only in IDLE
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE state
mem_rd_en  output  1  read strobe; data returns on mem_rd_data the next cycle
mem_rd_addr  output  AW  lane being read
mem_rd_data  input  W  lane data, valid one cycle after mem_rd_en
mem_wr_en  output  1  write strobe, one cycle per lane
mem_wr_addr  output  AW  lane being written
mem_wr_data  output  W  rotated lane

Behaviour:
- Reset: state IDLE; lane counter = 1; shift counter = 0; shift register = 0. All outputs are 0 during and after reset.
- Offset ROM, indices 0..24: 0,1,62,28,27,36,44,6,55,20,3,10,43,25,39,41,45,15,21,8,18,2,61,56,14. k = ROM[lane] mod W.
- FSM states are IDLE, READ, LOAD, SHIFT, WRITE, NEXT_LANE and DONE.
- IDLE: if start=1, go to READ with lane=1. Otherwise stay.
- READ: mem_rd_en=1 and mem_rd_addr=lane. Go to LOAD.
- LOAD: capture mem_rd_data into the shift register and set the shift counter to k. Go to SHIFT if k>0, else go to WRITE.
- SHIFT: one bit per cycle, sreg <= {sreg[0], sreg[W-1:1]}. Decrement the counter; when the counter reaches 1, go to WRITE. The state lasts exactly k cycles.
- WRITE: mem_wr_en=1, mem_wr_addr=lane, mem_wr_data=sreg. Go to DONE if lane==24, else go to READ with lane+1.
- Lane increment is done on the WRITE to READ transition; NEXT_LANE is merged into WRITE and is not a separate cycle.
- DONE: done=1 for one cycle, lane is reset to 1, then go to IDLE.
- Lane 0 is never read or written (offset 0).
- Per-lane latency is 3+k cycles.
- For W=64, the sum of k over lanes 1..24 is 680. done is high 753 cycles after the edge that samples start. busy is high for exactly 753 cycles.
- A start asserted while busy is ignored; it is not queued.
- A start held high continuously restarts a new pass on the cycle after DONE, since IDLE samples it.
- Reset asserted mid-pass aborts immediately. No further reads or writes occur. Lanes already written stay modified.
- mem_rd_en and mem_wr_en are never both high in the same cycle.
- Addresses are 0 whenever the matching strobe is low.

Optional Feature:
INV_RHO_ROTATE_BARREL_EN.
- Defined: SHIFT is a single cycle that applies a combinational barrel rotate right by k. SHIFT is entered even when k=0. Per-lane latency is 4 cycles; done comes 97 cycles after the start edge.
- Undefined: the bit-serial shifter described above, with 753-cycle latency at W=64.
- The memory write contents are identical in both builds.

Test Plan:
1. Lane values: lane1=0x0000000000000001, lane2=0x0000000000000001, lane0=0xDEADBEEFDEADBEEF; pulse start. Expected: lane1=0x8000000000000000, lane2=0x0000000000000004, lane0 unchanged. No write ever targets address 0.
2. Load a random 25-lane state and apply the forward rotate model; then run this block. Expected: the memory equals the original state bit-exactly, for 20 random seeds.
3. Latency check on a single start pulse. Expected: busy high for 753 cycles, done a single pulse on cycle 753, exactly 24 mem_wr_en pulses. With INV_RHO_ROTATE_BARREL_EN: 97 cycles.
4. Pulse start again at cycle 100 of a pass. Expected: no restart, done still at cycle 753, still 24 writes.
5. Assert rst at cycle 200, then release. Expected: all outputs 0 next cycle, FSM in IDLE. A new start completes a full pass normally.
6. W=8, lane2=0x01. Expected: rotate right by 62 mod 8 = 6, giving lane2=0x04. Lane7 (offset 6) behaves identically.
